// File: rtl/throttle_multi.sv
// Button-selectable clock throttle: two debounced rate buttons pick one of
// NUM_LEVELS half-periods; a frozen-able divider produces slow_clk and tick.

module pb_debounce #(
    parameter int DB_LEN = 8
) (
    input  logic CLK_50,
    input  logic reset,
    input  logic pb,
    output logic press
);
    logic [1:0]        sync;
    logic [DB_LEN-1:0] sh;
    logic              db;
    logic              db_q;

    always_ff @(posedge CLK_50 or posedge reset) begin
        if (reset) begin
            sync <= '0;
            sh   <= '0;
            db   <= 1'b0;
            db_q <= 1'b0;
        end else begin
            sync <= {sync[0], pb};
            sh   <= {sh[DB_LEN-2:0], sync[1]};
            // Mixed history keeps the previous debounced level.
            if (&sh)
                db <= 1'b1;
            else if (~|sh)
                db <= 1'b0;
            db_q <= db;
        end
    end

    assign press = db & ~db_q;
endmodule

module throttle_multi #(
    parameter int NUM_LEVELS = 6,
    parameter int BASE_HALF  = 25000000,
    parameter int CNT_W      = 26,
    parameter int DB_LEN     = 8,
    parameter int INIT_LEVEL = 0,
    localparam int LVL_W     = (NUM_LEVELS > 2) ? $clog2(NUM_LEVELS) : 1
) (
    input  logic             CLK_50,
    input  logic             reset,
    input  logic             pb_freq_up,
    input  logic             pb_freq_dn,
    input  logic             run,
    output logic             slow_clk,
    output logic             tick,
    output logic [LVL_W-1:0] freq_num
);
    localparam int NUM_BTN = 2;
    localparam logic [LVL_W-1:0] MAX_LVL = LVL_W'(NUM_LEVELS - 1);

    if (NUM_LEVELS < 2) begin : g_bad_levels
        $error("throttle_multi: NUM_LEVELS must be at least 2");
    end
    if (BASE_HALF < 1 || (BASE_HALF >> CNT_W) != 0) begin : g_bad_half
        $error("throttle_multi: BASE_HALF must be >= 1 and fit in CNT_W bits");
    end
    if (DB_LEN < 2) begin : g_bad_db
        $error("throttle_multi: DB_LEN must be at least 2");
    end
    if (INIT_LEVEL < 0 || INIT_LEVEL >= NUM_LEVELS) begin : g_bad_init
        $error("throttle_multi: INIT_LEVEL must be below NUM_LEVELS");
    end

    // Terminal counts (HALF[k]-1) packed per level, folded at elaboration.
    function automatic logic [NUM_LEVELS*CNT_W-1:0] build_term();
        logic [NUM_LEVELS*CNT_W-1:0] t;
        int h;
        t = '0;
        for (int k = 0; k < NUM_LEVELS; k++) begin
            h = BASE_HALF / (k + 1);
            if (h < 1)
                h = 1;
            t[k*CNT_W +: CNT_W] = CNT_W'(h - 1);
        end
        return t;
    endfunction

    localparam logic [NUM_LEVELS*CNT_W-1:0] TERM_TBL = build_term();

    logic [NUM_BTN-1:0] press;      // [0] up, [1] down
    logic [LVL_W-1:0]   lvl_nxt;
    logic               lvl_chg;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   term;
    logic               at_term;

    pb_debounce #(.DB_LEN(DB_LEN)) u_pb [NUM_BTN-1:0] (
        .CLK_50 (CLK_50),
        .reset  (reset),
        .pb     ({pb_freq_dn, pb_freq_up}),
        .press  (press)
    );

    // Simultaneous up and down cancel; saturated steps are no-ops.
    always_comb begin
        lvl_nxt = freq_num;
        if (press[0] && !press[1] && freq_num != MAX_LVL)
            lvl_nxt = freq_num + LVL_W'(1);
        else if (press[1] && !press[0] && freq_num != '0)
            lvl_nxt = freq_num - LVL_W'(1);
    end

    assign lvl_chg = (lvl_nxt != freq_num);
    assign term    = TERM_TBL[freq_num*CNT_W +: CNT_W];
    assign at_term = (cnt == term);

    always_ff @(posedge CLK_50 or posedge reset) begin
        if (reset) begin
            freq_num <= LVL_W'(INIT_LEVEL);
            cnt      <= '0;
            slow_clk <= 1'b0;
            tick     <= 1'b0;
        end else begin
            freq_num <= lvl_nxt;
            tick     <= 1'b0;
            // A level change restarts the period and outranks a terminal count.
            if (lvl_chg) begin
                cnt <= '0;
            end else if (run) begin
                if (at_term) begin
                    cnt      <= '0;
                    slow_clk <= ~slow_clk;
                    tick     <= ~slow_clk;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end
endmodule

// File: doc/throttle_multi.md
THROTTLE_MULTI -- requirements
Module: throttle_multi

Interface
REQ-001 SHALL have parameter NUM_LEVELS, default 6: number of selectable rates, minimum 2.
REQ-002 SHALL have parameter BASE_HALF, default 25000000: half-period of level 0, in CLK_50 cycles, minimum 1.
REQ-003 SHALL have parameter CNT_W, default 26: width of the divider counter; BASE_HALF SHALL fit in CNT_W bits, otherwise elaboration SHALL fail.
REQ-004 SHALL have parameter DB_LEN, default 8: number of consecutive equal samples needed to accept a button level, minimum 2.
REQ-005 SHALL have parameter INIT_LEVEL, default 0: level loaded at reset; it SHALL be below NUM_LEVELS, otherwise elaboration SHALL fail.
REQ-006 SHALL have local width LVL_W = clog2(NUM_LEVELS), with a minimum of 1.
REQ-007 SHALL have port CLK_50, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-008 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-009 SHALL have port pb_freq_up, input, 1 bit: raw, asynchronous rate-up button.
REQ-010 SHALL have port pb_freq_dn, input, 1 bit: raw, asynchronous rate-down button.
REQ-011 SHALL have port run, input, 1 bit: divider enable; when low, the divider is frozen.
REQ-012 SHALL have port slow_clk, output, 1 bit: registered 50%-duty square wave.
REQ-013 SHALL have port tick, output, 1 bit: registered one-cycle pulse on each slow_clk rise.
REQ-014 SHALL have port freq_num, output, LVL_W bits: the current level.

Function
REQ-015 Each button SHALL pass through a 2-flop synchroniser, then a DB_LEN-bit shift register.
REQ-016 The debounced level of each button SHALL set when all DB_LEN shift bits are 1, clear when all are 0, and hold otherwise.
REQ-017 A press SHALL be a 0->1 transition of the debounced level; each press SHALL produce exactly one step, regardless of hold time.
REQ-018 freq_num SHALL update on rising edge DB_LEN+4 after a button input goes high and stays high.
REQ-019 An up press SHALL increment freq_num, saturating at NUM_LEVELS-1; no wrap-around.
REQ-020 A down press SHALL decrement freq_num, saturating at 0; no wrap-around.
REQ-021 An up press and a down press detected in the same cycle SHALL leave freq_num unchanged.
REQ-022 A press at a saturation limit SHALL leave freq_num, the counter and slow_clk unchanged.
REQ-023 Half-period table: HALF[k] = max(1, floor(BASE_HALF/(k+1))) for k = 0..NUM_LEVELS-1.
REQ-024 The table SHALL be computed at elaboration; there SHALL be no runtime divider.
REQ-025 With run=1, the counter SHALL count 0..HALF[freq_num]-1.
REQ-026 On the cycle the counter equals HALF[freq_num]-1: the counter SHALL go to 0 and slow_clk SHALL toggle.
REQ-027 With HALF=1, slow_clk SHALL toggle every cycle.
REQ-028 tick SHALL be 1 exactly in the first cycle slow_clk is 1 after a 0->1 toggle, and 0 otherwise.
REQ-029 With run=0: counter and slow_clk SHALL hold, tick SHALL be 0, and button processing SHALL continue.
REQ-030 On the edge freq_num changes, the counter SHALL clear to 0 and slow_clk SHALL hold, so the new period starts cleanly.
REQ-031 The level change SHALL take priority over a terminal count in the same cycle: no toggle.
REQ-032 Counter comparisons SHALL be CNT_W bits wide, unsigned.

Reset
REQ-033 While reset=1, asynchronously: synchroniser flops, shift registers, debounced levels, edge-history flops and the counter SHALL be 0; slow_clk=0, tick=0, freq_num=INIT_LEVEL.
REQ-034 A reset asserted mid-count or mid-press SHALL discard all partial state; after release, a held button SHALL count as a new press only after a full debounce.
REQ-035 Outputs SHALL be valid on the first rising edge after reset deasserts; there SHALL be no extra warm-up cycles.

Verification (NUM_LEVELS=4, BASE_HALF=12, DB_LEN=4, INIT_LEVEL=0; halves 12,6,4,3)
REQ-036 Reset, run=1, no buttons -> slow_clk toggles every 12 cycles; tick is high 1 cycle per 24; freq_num=0.
REQ-037 pb_freq_up held high 50 cycles -> freq_num=1 at edge 8 and never 2; period becomes 12 cycles, first toggle 6 cycles after the change.
REQ-038 Glitch pulses of 3 cycles on pb_freq_dn -> no change; 4 up presses from level 0 -> freq_num=3, half-period 3; a 5th press -> no change.
REQ-039 Both buttons rise in the same cycle at level 2 -> freq_num stays 2; counter is not cleared.
REQ-040 run=0 for 20 cycles mid-period -> slow_clk and counter frozen, tick=0; after run=1, the count resumes from the held value.
REQ-041 reset pulse while the counter is at 7 and up is half-debounced -> all outputs return to reset values immediately; no level step is taken until a full debounce.
